// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL powerdown / lock-filter / staged domain reset sequencer
//
// Sequences the clock/reset subsystem from the free-running oscillator clock:
// IDLE -> PD (PLLs powered down) -> WAIT_LOCK (filtered lock) -> RELEASE
// (domain resets released one by one, index 0 first) -> RUN.
// Lock loss in RELEASE/RUN re-asserts every domain reset, bumps a saturating
// event counter and re-runs from PD. Loss of the external reset request
// returns to IDLE from any state and wins over a simultaneous lock loss.
//
// Optional feature macro: RSTSEQ_LOCK_TIMEOUT_EN
//   defined   - WAIT_LOCK retries through PD after LOCK_TIMEOUT cycles without lock
//   undefined - WAIT_LOCK waits indefinitely, LOCK_TIMEOUT is not used by the logic
//
// Ports:
//   clk_i              oscillator clock
//   rst_i              asynchronous active-high reset
//   ext_rst_n_i        external reset request, active-low, async (2-FF synchronised)
//   init_done_i        device init complete, async (2-FF synchronised)
//   pll_lock_i         per-PLL lock flags, async (2-FF synchronised per bit)
//   pll_powerdown_n_o  PLL powerdown, active-low, all bits identical
//   domain_reset_n_o   per-domain reset requests, active-low
//   ready_o            high only in RUN
//   state_o            IDLE=0 PD=1 WAIT_LOCK=2 RELEASE=3 RUN=4
//   lock_loss_cnt_o    saturating lock-loss event count
module pll_reset_sequencer #(
    parameter int N_PLL        = 2,
    parameter int N_DOM        = 3,
    parameter int PD_CYCLES    = 16,
    parameter int LOCK_FILTER  = 64,
    parameter int STAGE_DLY    = 32,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ext_rst_n_i,
    input  logic             init_done_i,
    input  logic [N_PLL-1:0] pll_lock_i,
    output logic [N_PLL-1:0] pll_powerdown_n_o,
    output logic [N_DOM-1:0] domain_reset_n_o,
    output logic             ready_o,
    output logic [2:0]       state_o,
    output logic [7:0]       lock_loss_cnt_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PD      = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;

    // One counter serves PD dwell, lock filter and release stage spacing,
    // since only one of them is active in any state.
    localparam int CNT_MAX_A = (PD_CYCLES > LOCK_FILTER) ? PD_CYCLES : LOCK_FILTER;
    localparam int CNT_MAX   = (CNT_MAX_A > STAGE_DLY) ? CNT_MAX_A : STAGE_DLY;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PD_LAST    = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [N_DOM-1:0] DOM_ONE    = N_DOM'(1);

    generate
        if (N_PLL < 1 || N_DOM < 1 || PD_CYCLES < 1 || LOCK_FILTER < 1 ||
            STAGE_DLY < 1 || LOCK_TIMEOUT < 1) begin : g_bad_params
            $error("pll_reset_sequencer: illegal parameter value");
        end
    endgenerate

    // Input synchronisers
    logic             ext_s1_q, ext_s2_q;
    logic             init_s1_q, init_s2_q;
    logic [N_PLL-1:0] lock_s1_q, lock_s2_q;

    logic ext_ok, init_ok, lock_all;
    assign ext_ok   = ext_s2_q;
    assign init_ok  = init_s2_q;
    assign lock_all = &lock_s2_q;

    // FSM and datapath state
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_DOM-1:0] dom_q, dom_d;
    logic [7:0]       loss_q, loss_d;
    logic             pd_n_q, pd_n_d;
    logic             ready_q, ready_d;
    logic             lock_lost;
    logic             timeout_hit;

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

    logic [TO_W-1:0] dwell_q, dwell_d;

    // Dwell restarts from zero on every entry into WAIT_LOCK.
    assign dwell_d     = (state_q == S_WAIT && state_d == S_WAIT) ? dwell_q + TO_W'(1) : '0;
    assign timeout_hit = (dwell_q == TO_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dom_d     = dom_q;
        loss_d    = loss_q;
        lock_lost = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ext_ok && init_ok) begin
                    state_d = S_PD;
                    cnt_d   = '0;
                end
            end
            S_PD: begin
                if (!ext_ok) begin
                    state_d = S_IDLE;
                end else if (cnt_q == PD_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (!ext_ok) begin
                    state_d = S_IDLE;
                end else if (lock_all && cnt_q == FILT_LAST) begin
                    // Bit 0 is released on the first RELEASE cycle.
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    dom_d   = DOM_ONE;
                end else if (timeout_hit) begin
                    state_d = S_PD;
                    cnt_d   = '0;
                end else if (lock_all) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_RELEASE: begin
                if (!ext_ok) begin
                    state_d = S_IDLE;
                end else if (!lock_all) begin
                    lock_lost = 1'b1;
                end else if (&dom_q) begin
                    state_d = S_RUN;
                end else if (cnt_q == STAGE_LAST) begin
                    dom_d = (dom_q << 1) | DOM_ONE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!ext_ok) begin
                    state_d = S_IDLE;
                end else if (!lock_all) begin
                    lock_lost = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (lock_lost) begin
            state_d = S_PD;
            cnt_d   = '0;
            if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end

        if (state_d == S_IDLE) begin
            cnt_d = '0;
        end

        // Domains may only be out of reset in RELEASE and RUN.
        if (state_d != S_RELEASE && state_d != S_RUN) begin
            dom_d = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with state_o.
    assign pd_n_d  = (state_d == S_WAIT) || (state_d == S_RELEASE) || (state_d == S_RUN);
    assign ready_d = (state_d == S_RUN);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ext_s1_q  <= 1'b0;
            ext_s2_q  <= 1'b0;
            init_s1_q <= 1'b0;
            init_s2_q <= 1'b0;
            lock_s1_q <= '0;
            lock_s2_q <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dom_q     <= '0;
            loss_q    <= 8'd0;
            pd_n_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ext_s1_q  <= ext_rst_n_i;
            ext_s2_q  <= ext_s1_q;
            init_s1_q <= init_done_i;
            init_s2_q <= init_s1_q;
            lock_s1_q <= pll_lock_i;
            lock_s2_q <= lock_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dom_q     <= dom_d;
            loss_q    <= loss_d;
            pd_n_q    <= pd_n_d;
            ready_q   <= ready_d;
        end
    end

    assign pll_powerdown_n_o = {N_PLL{pd_n_q}};
    assign domain_reset_n_o  = dom_q;
    assign ready_o           = ready_q;
    assign state_o           = state_q;
    assign lock_loss_cnt_o   = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext_rst_n;
    logic       init_done;
    logic [1:0] pll_lock;
    logic [1:0] pll_powerdown_n;
    logic [2:0] domain_reset_n;
    logic       ready;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .N_PLL       (2),
        .N_DOM       (3),
        .PD_CYCLES   (4),
        .LOCK_FILTER (8),
        .STAGE_DLY   (5),
        .LOCK_TIMEOUT(100)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ext_rst_n_i      (ext_rst_n),
        .init_done_i      (init_done),
        .pll_lock_i       (pll_lock),
        .pll_powerdown_n_o(pll_powerdown_n),
        .domain_reset_n_o (domain_reset_n),
        .ready_o          (ready),
        .state_o          (state),
        .lock_loss_cnt_o  (lock_loss_cnt)
    );

    typedef struct {
        logic       ext;
        logic       init;
        logic [1:0] lock;
        int         wait_n;
        logic [2:0] st;
        logic [2:0] dom;
        logic [1:0] pd;
        logic       rdy;
    } vec_t;

    // Full sequence measured from the first sample after entering PD.
    vec_t seq_tab [10];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [2:0] dom,
                         input logic [1:0] pd, input logic rdy, input logic [7:0] cnt);
        checks++;
        if ({state, domain_reset_n, pll_powerdown_n, ready, lock_loss_cnt} !== {st, dom, pd, rdy, cnt}) begin
            errors++;
            $display("FAIL %s: got state=%0d dom=%b pd=%b ready=%b cnt=%0d, expected state=%0d dom=%b pd=%b ready=%b cnt=%0d",
                     name, state, domain_reset_n, pll_powerdown_n, ready, lock_loss_cnt,
                     st, dom, pd, rdy, cnt);
        end
    endtask

    task automatic check_cnt(input string name, input logic [7:0] cnt);
        checks++;
        if (lock_loss_cnt !== cnt) begin
            errors++;
            $display("FAIL %s: got cnt=%0d, expected cnt=%0d", name, lock_loss_cnt, cnt);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (state !== target && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (state !== target) begin
            errors++;
            $display("FAIL %s: state=%0d, expected %0d within %0d cycles", name, state, target, budget);
        end
    endtask

    task automatic run_seq(input string tag, input logic [7:0] cnt);
        for (int i = 0; i < 10; i++) begin
            ext_rst_n = seq_tab[i].ext;
            init_done = seq_tab[i].init;
            pll_lock  = seq_tab[i].lock;
            step(seq_tab[i].wait_n);
            check($sformatf("%s row%0d", tag, i), seq_tab[i].st, seq_tab[i].dom,
                  seq_tab[i].pd, seq_tab[i].rdy, cnt);
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        seq_tab[0] = '{1'b1, 1'b1, 2'b11, 0, 3'd1, 3'b000, 2'b00, 1'b0};
        seq_tab[1] = '{1'b1, 1'b1, 2'b11, 3, 3'd1, 3'b000, 2'b00, 1'b0};
        seq_tab[2] = '{1'b1, 1'b1, 2'b11, 1, 3'd2, 3'b000, 2'b11, 1'b0};
        seq_tab[3] = '{1'b1, 1'b1, 2'b11, 7, 3'd2, 3'b000, 2'b11, 1'b0};
        seq_tab[4] = '{1'b1, 1'b1, 2'b11, 1, 3'd3, 3'b001, 2'b11, 1'b0};
        seq_tab[5] = '{1'b1, 1'b1, 2'b11, 4, 3'd3, 3'b001, 2'b11, 1'b0};
        seq_tab[6] = '{1'b1, 1'b1, 2'b11, 1, 3'd3, 3'b011, 2'b11, 1'b0};
        seq_tab[7] = '{1'b1, 1'b1, 2'b11, 4, 3'd3, 3'b011, 2'b11, 1'b0};
        seq_tab[8] = '{1'b1, 1'b1, 2'b11, 1, 3'd3, 3'b111, 2'b11, 1'b0};
        seq_tab[9] = '{1'b1, 1'b1, 2'b11, 1, 3'd4, 3'b111, 2'b11, 1'b1};

        // Power-up, with INIT_DONE held low for a while in IDLE
        rst       = 1'b1;
        ext_rst_n = 1'b1;
        init_done = 1'b0;
        pll_lock  = 2'b11;
        step(2);
        check("rst_hold", 3'd0, 3'b000, 2'b00, 1'b0, 8'd0);
        rst = 1'b0;
        step(5);
        check("idle_no_init", 3'd0, 3'b000, 2'b00, 1'b0, 8'd0);
        init_done = 1'b1;
        step(3);
        run_seq("pwrup", 8'd0);

        // Lock loss in RUN (INIT_DONE dropping meanwhile is ignored)
        pll_lock  = 2'b01;
        init_done = 1'b0;
        step(1);
        pll_lock = 2'b11;
        step(1);
        check("loss_pre", 3'd4, 3'b111, 2'b11, 1'b1, 8'd0);
        step(1);
        run_seq("loss", 8'd1);

        // EXT_RST_N from RUN, then during RELEASE with 011 plus simultaneous lock loss
        ext_rst_n = 1'b0;
        step(3);
        check("ext_run_idle", 3'd0, 3'b000, 2'b00, 1'b0, 8'd1);
        ext_rst_n = 1'b1;
        step(3);
        check("ext_restart_pd", 3'd1, 3'b000, 2'b00, 1'b0, 8'd1);
        step(16);
        ext_rst_n = 1'b0;
        pll_lock  = 2'b00;
        step(1);
        check("ext_rel_011a", 3'd3, 3'b011, 2'b11, 1'b0, 8'd1);
        step(1);
        check("ext_rel_011b", 3'd3, 3'b011, 2'b11, 1'b0, 8'd1);
        step(1);
        check("ext_rel_idle", 3'd0, 3'b000, 2'b00, 1'b0, 8'd1);
        ext_rst_n = 1'b1;
        pll_lock  = 2'b11;
        step(3);
        run_seq("ext", 8'd1);

        // One-cycle lock glitch after 6 locked WAIT_LOCK cycles
        ext_rst_n = 1'b0;
        step(3);
        ext_rst_n = 1'b1;
        step(3);
        check("glitch_pd", 3'd1, 3'b000, 2'b00, 1'b0, 8'd1);
        step(8);
        pll_lock = 2'b01;
        step(1);
        pll_lock = 2'b11;
        step(3);
        check("glitch_no_early_rel", 3'd2, 3'b000, 2'b11, 1'b0, 8'd1);
        step(6);
        check("glitch_wait_last", 3'd2, 3'b000, 2'b11, 1'b0, 8'd1);
        step(1);
        check("glitch_rel", 3'd3, 3'b001, 2'b11, 1'b0, 8'd1);

        // No lock at all: wait forever, or retry through PD with the timeout
        ext_rst_n = 1'b0;
        pll_lock  = 2'b00;
        step(3);
        check("nolock_idle", 3'd0, 3'b000, 2'b00, 1'b0, 8'd1);
        ext_rst_n = 1'b1;
        step(3);
        check("nolock_pd", 3'd1, 3'b000, 2'b00, 1'b0, 8'd1);
        step(4);
        check("nolock_wait", 3'd2, 3'b000, 2'b11, 1'b0, 8'd1);
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
        step(99);
        check("to_wait_last", 3'd2, 3'b000, 2'b11, 1'b0, 8'd1);
        step(1);
        check("to_pd", 3'd1, 3'b000, 2'b00, 1'b0, 8'd1);
        step(3);
        check("to_pd_last", 3'd1, 3'b000, 2'b00, 1'b0, 8'd1);
        step(1);
        check("to_wait_again", 3'd2, 3'b000, 2'b11, 1'b0, 8'd1);
`else
        step(150);
        check("nolock_stays_wait", 3'd2, 3'b000, 2'b11, 1'b0, 8'd1);
`endif

        // Counter saturation: 256 more lock-loss events (257 total)
        pll_lock = 2'b11;
        for (int i = 0; i < 256; i++) begin
            wait_state(3'd3, 200, $sformatf("sat reach rel %0d", i));
            pll_lock = 2'b00;
            wait_state(3'd1, 20, $sformatf("sat reach pd %0d", i));
            pll_lock = 2'b11;
            if (i == 252) check_cnt("sat_254", 8'd254);
            if (i == 253) check_cnt("sat_255", 8'd255);
        end
        check_cnt("sat_hold", 8'd255);

        // Asynchronous reset mid-RELEASE
        wait_state(3'd3, 200, "arst reach rel");
        step(6);
        check("arst_pre", 3'd3, 3'b011, 2'b11, 1'b0, 8'd255);
        rst = 1'b1;
        #1;
        check("arst_now", 3'd0, 3'b000, 2'b00, 1'b0, 8'd0);
        step(2);
        rst = 1'b0;
        step(2);
        check("arst_idle", 3'd0, 3'b000, 2'b00, 1'b0, 8'd0);
        step(1);
        run_seq("arst", 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
